// File: rtl/img_sram_ctrl_if.sv
// Signal bundle between the image SRAM initiator and the SRAM wrapper.
// The initiator drives the registered address/data/control and samples dout.
interface img_sram_intf;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
    logic [7:0] dout;
    logic       write_en;
    logic       sense_en;

    modport mst (output row, col, din, write_en, sense_en, input dout);
    modport slv (input row, col, din, write_en, sense_en, output dout);
endinterface

// File: rtl/img_sram_ctrl.sv
// Burst initiator for the 256x256x8 image SRAM: sequences one access per cycle
// and buffers read returns in a small FIFO so rd_ready back-pressure never drops bytes.
module img_sram_ctrl #(
    parameter int RD_FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_row,
    input  logic [7:0] cmd_col,
    input  logic [7:0] cmd_len,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       busy,
    img_sram_intf.mst  intf
);
    localparam int PTR_W = (RD_FIFO_DEPTH > 2) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(RD_FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t           state;
    logic [15:0]      addr;
    logic [7:0]       count;
    logic             rd_inflight;
    logic [7:0]       fifo_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] occ;

    logic             cmd_fire;
    logic             wr_fire;
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] committed;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign push     = rd_inflight;

    // A read may issue only if its byte is guaranteed a FIFO slot when it returns.
    assign committed = occ + OCC_W'(rd_inflight) - OCC_W'(pop);
    assign issue     = (state == READ) && (committed < OCC_W'(RD_FIFO_DEPTH));

    assign rd_valid = (occ != '0);
    assign rd_data  = fifo_mem[rptr];
    assign busy     = (state != IDLE) || rd_inflight || intf.write_en || (occ != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            cmd_ready     <= 1'b0;
            wr_ready      <= 1'b0;
            rd_inflight   <= 1'b0;
            intf.row      <= '0;
            intf.col      <= '0;
            intf.din      <= '0;
            intf.write_en <= 1'b0;
            intf.sense_en <= 1'b1;
        end else begin
            // Hold unless a Write or Read is registered below.
            intf.write_en <= 1'b0;
            intf.sense_en <= 1'b1;
            rd_inflight   <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= !cmd_fire;
                    if (cmd_fire) begin
                        addr     <= {cmd_row, cmd_col};
                        count    <= cmd_len;
                        wr_ready <= cmd_write;
                        state    <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        intf.row      <= addr[15:8];
                        intf.col      <= addr[7:0];
                        intf.din      <= wr_data;
                        intf.write_en <= 1'b1;
                        intf.sense_en <= 1'b1;
                        addr          <= addr + 16'd1;
                        count         <= count - 8'd1;
                        if (count == 8'd0) begin
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        intf.row      <= addr[15:8];
                        intf.col      <= addr[7:0];
                        intf.write_en <= 1'b0;
                        intf.sense_en <= 1'b0;
                        rd_inflight   <= 1'b1;
                        addr          <= addr + 16'd1;
                        count         <= count - 8'd1;
                        if (count == 8'd0) begin
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    wr_ready  <= 1'b0;
                end
            endcase
        end
    end

    // dout is valid at the edge closing the Read cycle, flagged by rd_inflight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= intf.dout;
                wptr           <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end
endmodule

// File: doc/img_sram_ctrl.md
# img_sram_ctrl

Initiator for the 256x256x8 image SRAM interface. It accepts burst read and write commands over a valid/ready request port and streams write bytes in and read bytes out. It generates the row/col/din/write_en/sense_en sequencing the SRAM wrapper requires: all SRAM-side signals change only on posedge clk. It sits between the convolution datapath / host loader and the image SRAM.

## Interface
Parameters:
- RD_FIFO_DEPTH, 2 — read-return FIFO entries; must be >= 2 for full throughput.

Ports:
- clk  in  1  single clock; also the clock of the SRAM interface.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both are high at posedge.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_row  in  8  start row.
- cmd_col  in  8  start column.
- cmd_len  in  8  burst length minus 1 (1..256 bytes).
- wr_valid / wr_ready  in / out  1 / 1  write-data handshake.
- wr_data  in  8  write byte.
- rd_valid / rd_ready  out / in  1 / 1  read-data handshake.
- rd_data  out  8  read byte (FIFO head).
- busy  out  1  high when not IDLE, an SRAM access is in flight, or the FIFO is non-empty.
- intf  img_sram_intf.mst  —  drives row[7:0], col[7:0], din[7:0], write_en, sense_en; samples dout[7:0].

## Operation
- SRAM access encoding, one clk cycle per access:
  - Write: write_en=1, sense_en=1.
  - Read: write_en=0, sense_en=0.
  - Hold: write_en=0, sense_en=1.
- row, col, din, write_en and sense_en are registered outputs. Each access occupies exactly the cycle following the edge that registers it, and signals are held constant for that whole cycle.
- States:
  - IDLE: cmd_ready=1, SRAM in Hold. On cmd handshake, latch address and count=cmd_len, then go to WRITE if cmd_write, else READ.
  - WRITE: wr_ready=1.
    - Each wr handshake registers a Write access: row/col = current address, din = wr_data. Then address increments and count decrements.
    - Handshake with count==0 returns to IDLE.
    - No handshake registers Hold.
  - READ: a Read access is issued at an edge iff FIFO occupancy + in-flight reads − (pop at this edge) < RD_FIFO_DEPTH. Otherwise Hold is registered.
    - Each issue increments the address and decrements count.
    - Issue with count==0 returns to IDLE.
- Read return: dout is sampled at the posedge ending the Read access cycle and pushed into the FIFO. rd_valid = FIFO non-empty.
- Address arithmetic: {row,col} is a 16-bit counter incremented by 1.
  - col 255 carries into row+1.
  - (255,255) wraps to (0,0).
- Back-to-back commands: the next command may be accepted in IDLE while the final access of the previous burst is still in its cycle. Ordering is preserved because accesses are strictly sequential.
- Reset (assert at any time, including mid-burst):
  - state=IDLE, row=col=din=0, write_en=0, sense_en=1, FIFO and in-flight flag cleared.
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0.
  - The pending burst is discarded. Contents of a byte interrupted mid-write are undefined.
- cmd_ready goes high at the first posedge after rst_n deasserts.

## Timing
- Write: wr handshake at edge W → SRAM Write during cycle W..W+1. Throughput is 1 byte/cycle.
- Read: cmd accepted at edge E0 → first Read issued at E1 → dout captured at E2 → rd_valid high after E2.
  - Latency is 2 cycles from command accept.
  - Sustained 1 byte/cycle while rd_ready=1.
- With rd_ready=0: at most RD_FIFO_DEPTH bytes are buffered, after which Hold is issued. No byte is dropped or duplicated.
- busy falls at the edge after the last FIFO pop with no access in flight.

## Test plan
- Write 1 byte 0xA5 at (3,7), then read 1 byte at (3,7) → one rd_valid beat with rd_data=0xA5. Write access shows write_en=1, sense_en=1 for exactly one cycle.
- Write burst cmd_len=255 at (0,250) with data = index, then read it back → 256 bytes 0..255 in order. Addresses run (0,250)..(0,255),(1,0)..(1,249).
- Read burst of 4 at (255,254) → accesses at (255,254),(255,255),(0,0),(0,1), verifying wrap.
- Read burst of 16 with rd_ready toggled randomly and held low for 10 cycles → no more than 2 reads outstanding plus buffered. All 16 bytes are delivered exactly once and in order.
- Write burst of 8 with wr_valid gaps → Hold (write_en=0, sense_en=1) in gap cycles. Readback matches.
- Assert rst_n=0 mid-read-burst at byte 5 of 10 → outputs go to reset values immediately. After release, cmd_ready=1 and a new 2-byte read returns correct data.
